// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: modulo pointer increment and the parameter-legality check
// used by every FIFO generation.
package fifo_pkg;

    // Wraps at depth-1 without assuming a power-of-two depth.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

`ifndef FIFO_CHECK_PARAMS
`define FIFO_CHECK_PARAMS(depth, af, ae) if (((depth) < 2) || ((af) < 1) || ((af) > (depth)) || ((ae) < 0) || ((ae) > ((depth) - 1))) begin : g_param_err $error("fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL combination"); end
`endif

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer register; one instance per FIFO pointer.
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= AW'(ptr_next(32'(ptr), 32'(DEPTH)));
        end
    end

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of arbitrary depth with standard or first-word-fall-through
// output, occupancy/threshold flags and one-cycle overflow/underflow pulses.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 192,
    parameter int WIDTH    = 8,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wren,
    input  logic [WIDTH-1:0]         wrdata,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rden,
    output logic [WIDTH-1:0]         rddata,
    output logic                     rdvalid,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);

    `FIFO_CHECK_PARAMS(DEPTH, AF_LEVEL, AE_LEVEL)

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      cnt;
    logic [AW-1:0]    wrptr;
    logic [AW-1:0]    rdptr;
    logic             rd_ok;
    logic             wr_ok;

    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign rd_ok = rden & ~empty;
    assign wr_ok = wren & (~full | rd_ok);

    assign full         = (cnt == (AW+1)'(DEPTH));
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= (AW+1)'(AF_LEVEL));
    assign almost_empty = (cnt <= (AW+1)'(AE_LEVEL));
    assign level        = cnt;

    fifo_ptr_wrap #(.DEPTH(DEPTH), .AW(AW)) u_wrptr (
        .clk  (clk),
        .srst (srst),
        .inc  (wr_ok),
        .ptr  (wrptr)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH), .AW(AW)) u_rdptr (
        .clk  (clk),
        .srst (srst),
        .inc  (rd_ok),
        .ptr  (rdptr)
    );

    // On a full-and-both collision wrptr == rdptr: the read below sees the old word.
    always_ff @(posedge clk) begin
        if (wr_ok && !srst) begin
            mem[wrptr] <= wrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt <= '0;
        end else if (wr_ok && !rd_ok) begin
            cnt <= cnt + (AW+1)'(1);
        end else if (rd_ok && !wr_ok) begin
            cnt <= cnt - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wren & ~wr_ok;
            underflow <= rden & ~rd_ok;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rddata  = empty ? '0 : mem[rdptr];
            assign rdvalid = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] rddata_p1;
            logic             rdvalid_p1;

            // Stage p1: registered read port, one cycle after the accepting edge.
            always_ff @(posedge clk) begin
                if (srst) begin
                    rddata_p1  <= '0;
                    rdvalid_p1 <= 1'b0;
                end else begin
                    rdvalid_p1 <= rd_ok;
                    if (rd_ok) begin
                        rddata_p1 <= mem[rdptr];
                    end
                end
            end

            assign rddata  = rddata_p1;
            assign rdvalid = rdvalid_p1;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: standard-mode and FWFT instances at DEPTH=5,
// checked against a queue scoreboard.
module tb_sync_fifo_flex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       srst;

    logic       s_wren, s_rden;
    logic [7:0] s_wrdata, s_rddata;
    logic       s_full, s_af, s_rdvalid, s_empty, s_ae, s_ovf, s_unf;
    logic [3:0] s_level;

    logic       f_wren, f_rden;
    logic [7:0] f_wrdata, f_rddata;
    logic       f_full, f_af, f_rdvalid, f_empty, f_ae, f_ovf, f_unf;
    logic [3:0] f_level;

    int errors = 0;
    int checks = 0;

    logic [7:0] std_q[$];
    logic [7:0] fw_q[$];

    sync_fifo_flex #(.DEPTH(5), .WIDTH(8), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u_std (
        .clk          (clk),
        .srst         (srst),
        .wren         (s_wren),
        .wrdata       (s_wrdata),
        .full         (s_full),
        .almost_full  (s_af),
        .rden         (s_rden),
        .rddata       (s_rddata),
        .rdvalid      (s_rdvalid),
        .empty        (s_empty),
        .almost_empty (s_ae),
        .level        (s_level),
        .overflow     (s_ovf),
        .underflow    (s_unf)
    );

    sync_fifo_flex #(.DEPTH(5), .WIDTH(8), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(2)) u_fwft (
        .clk          (clk),
        .srst         (srst),
        .wren         (f_wren),
        .wrdata       (f_wrdata),
        .full         (f_full),
        .almost_full  (f_af),
        .rden         (f_rden),
        .rddata       (f_rddata),
        .rdvalid      (f_rdvalid),
        .empty        (f_empty),
        .almost_empty (f_ae),
        .level        (f_level),
        .overflow     (f_ovf),
        .underflow    (f_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Flags for the standard instance (DEPTH=5, AF_LEVEL=4, AE_LEVEL=1) from the scoreboard depth.
    task automatic check_std_flags(input string tag);
        int n;
        n = std_q.size();
        check({tag, ".level"}, 32'(s_level), 32'(n));
        check({tag, ".full"},  32'(s_full),  32'(n == 5));
        check({tag, ".empty"}, 32'(s_empty), 32'(n == 0));
        check({tag, ".af"},    32'(s_af),    32'(n >= 4));
        check({tag, ".ae"},    32'(s_ae),    32'(n <= 1));
    endtask

    task automatic check_fwft(input string tag);
        logic [7:0] e;
        e = (fw_q.size() != 0) ? fw_q[0] : 8'h00;
        check({tag, ".empty"},   32'(f_empty),   32'(fw_q.size() == 0));
        check({tag, ".rdvalid"}, 32'(f_rdvalid), 32'(fw_q.size() != 0));
        check({tag, ".rddata"},  32'(f_rddata),  32'(e));
        check({tag, ".level"},   32'(f_level),   32'(fw_q.size()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp;
        logic [7:0] d;

        srst = 1'b1;
        s_wren = 1'b0; s_rden = 1'b0; s_wrdata = 8'h00;
        f_wren = 1'b0; f_rden = 1'b0; f_wrdata = 8'h00;
        tick;
        tick;
        srst = 1'b0;

        check_std_flags("rst");
        check("rst.rdvalid", 32'(s_rdvalid), 32'd0);
        check("rst.rddata",  32'(s_rddata),  32'd0);
        check("rst.ovf",     32'(s_ovf),     32'd0);
        check("rst.unf",     32'(s_unf),     32'd0);
        check_fwft("rst.fwft");

        // Fill to full, watching thresholds step by step.
        for (int i = 0; i < 5; i++) begin
            s_wren = 1'b1;
            s_wrdata = 8'(8'h11 + i);
            tick;
            std_q.push_back(8'(8'h11 + i));
            check_std_flags($sformatf("fill%0d", i));
        end

        // Write into full with no read: rejected.
        s_wrdata = 8'h77;
        tick;
        s_wren = 1'b0;
        check("ovf.pulse", 32'(s_ovf), 32'd1);
        check_std_flags("ovf");
        tick;
        check("ovf.clear", 32'(s_ovf), 32'd0);

        // Simultaneous read and write while full.
        s_wren = 1'b1; s_wrdata = 8'h66; s_rden = 1'b1;
        tick;
        s_wren = 1'b0; s_rden = 1'b0;
        exp = std_q.pop_front();
        std_q.push_back(8'h66);
        check("coll.rddata",  32'(s_rddata),  32'(exp));
        check("coll.rdvalid", 32'(s_rdvalid), 32'd1);
        check("coll.ovf",     32'(s_ovf),     32'd0);
        check_std_flags("coll");

        // Drain across the pointer wrap.
        for (int i = 0; i < 5; i++) begin
            s_rden = 1'b1;
            tick;
            exp = std_q.pop_front();
            check($sformatf("drain%0d.rddata", i), 32'(s_rddata), 32'(exp));
            check($sformatf("drain%0d.rdvalid", i), 32'(s_rdvalid), 32'd1);
        end
        s_rden = 1'b0;
        check_std_flags("drained");
        tick;
        check("idle.rdvalid", 32'(s_rdvalid), 32'd0);
        check("idle.unf",     32'(s_unf),     32'd0);

        // Write and read together on empty: write taken, read rejected.
        s_wren = 1'b1; s_wrdata = 8'hA5; s_rden = 1'b1;
        tick;
        s_wren = 1'b0; s_rden = 1'b0;
        std_q.push_back(8'hA5);
        check("emptyboth.unf",     32'(s_unf),     32'd1);
        check("emptyboth.rdvalid", 32'(s_rdvalid), 32'd0);
        check_std_flags("emptyboth");
        tick;
        check("emptyboth.unfclr", 32'(s_unf), 32'd0);
        s_rden = 1'b1;
        tick;
        s_rden = 1'b0;
        exp = std_q.pop_front();
        check("emptyboth.rddata",  32'(s_rddata),  32'(exp));
        check("emptyboth.rdvalid1", 32'(s_rdvalid), 32'd1);

        // Sustained read+write at mid occupancy.
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            s_wren = 1'b1; s_wrdata = d;
            tick;
            std_q.push_back(d);
        end
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            s_wren = 1'b1; s_wrdata = d; s_rden = 1'b1;
            tick;
            exp = std_q.pop_front();
            std_q.push_back(d);
            check($sformatf("stream%0d.rddata", i), 32'(s_rddata), 32'(exp));
            check($sformatf("stream%0d.level", i), 32'(s_level), 32'd2);
        end
        s_rden = 1'b0;
        s_wrdata = 8'h5A;
        tick;
        s_wren = 1'b0;
        std_q.push_back(8'h5A);
        check_std_flags("lvl3");

        // Mid-stream reset with requests pending.
        srst = 1'b1; s_wren = 1'b1; s_wrdata = 8'h99; s_rden = 1'b1;
        tick;
        srst = 1'b0; s_wren = 1'b0; s_rden = 1'b0;
        std_q.delete();
        fw_q.delete();
        check_std_flags("midrst");
        check("midrst.rdvalid", 32'(s_rdvalid), 32'd0);
        check("midrst.ovf",     32'(s_ovf),     32'd0);
        check("midrst.unf",     32'(s_unf),     32'd0);
        check("midrst.rddata",  32'(s_rddata),  32'd0);
        tick;
        check_std_flags("postrst");

        // FWFT instance.
        f_wren = 1'b1; f_wrdata = 8'h3C;
        tick;
        f_wren = 1'b0;
        fw_q.push_back(8'h3C);
        check_fwft("fw.w3c");
        f_rden = 1'b1;
        tick;
        f_rden = 1'b0;
        void'(fw_q.pop_front());
        check_fwft("fw.pop3c");

        f_wren = 1'b1; f_wrdata = 8'h01;
        tick;
        fw_q.push_back(8'h01);
        check_fwft("fw.w01");
        f_wrdata = 8'h02;
        tick;
        f_wren = 1'b0;
        fw_q.push_back(8'h02);
        check_fwft("fw.w02");
        f_rden = 1'b1;
        tick;
        void'(fw_q.pop_front());
        check_fwft("fw.pop01");
        tick;
        void'(fw_q.pop_front());
        check_fwft("fw.pop02");
        tick;
        f_rden = 1'b0;
        check("fw.unf", 32'(f_unf), 32'd1);
        check_fwft("fw.emptyrd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
